// File: rtl/regfile_scoreboard.sv
// 8-entry register file with a per-register pending-write scoreboard.
// Supplies two combinational read operands, a flat view of all registers, and RAW hazard/stall flags.
module regfile_scoreboard #(
   parameter int WIDTH  = 16,
   parameter bit BYPASS = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         rd_sel1,
   input  logic [2:0]         rd_sel2,
   output logic [WIDTH-1:0]   rd_data1,
   output logic [WIDTH-1:0]   rd_data2,
   output logic [8*WIDTH-1:0] reg_flat,
   input  logic               issue_en,
   input  logic [2:0]         issue_reg,
   input  logic               wb_en,
   input  logic [2:0]         wb_reg,
   input  logic [WIDTH-1:0]   wb_data,
   output logic               hz1,
   output logic               hz2,
   output logic               stall,
   output logic [7:0]         busy
);

   logic [WIDTH-1:0] regs [8];
   logic [7:0]       busy_next;
   logic             byp1;
   logic             byp2;

   // Set is applied after clear so a same-register issue keeps the younger producer pending.
   always_comb begin
      busy_next = busy;
      if (wb_en)
         busy_next[wb_reg] = 1'b0;
      if (issue_en)
         busy_next[issue_reg] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++)
            regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wb_en)
            regs[wb_reg] <= wb_data;
         busy <= busy_next;
      end
   end

   always_comb begin
      byp1     = BYPASS && wb_en && (wb_reg == rd_sel1);
      byp2     = BYPASS && wb_en && (wb_reg == rd_sel2);
      rd_data1 = byp1 ? wb_data : regs[rd_sel1];
      rd_data2 = byp2 ? wb_data : regs[rd_sel2];
      hz1      = busy[rd_sel1] & ~byp1;
      hz2      = busy[rd_sel2] & ~byp2;
      stall    = hz1 | hz2;
   end

   // The flat view always shows stored state; forwarding applies to the read ports only.
   for (genvar g = 0; g < 8; g++) begin : g_flat
      assign reg_flat[g*WIDTH +: WIDTH] = regs[g];
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: table of per-cycle vectors plus hand sequences
// for forwarding on/off, mid-cycle reset, and write-back after reset.
module tb_regfile_scoreboard;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   rd_sel1, rd_sel2, issue_reg, wb_reg;
   logic         issue_en, wb_en;
   logic [15:0]  wb_data;
   logic [15:0]  rd_data1, rd_data2, rd_data1_nb, rd_data2_nb;
   logic [127:0] reg_flat, reg_flat_nb;
   logic         hz1, hz2, stall, hz1_nb, hz2_nb, stall_nb;
   logic [7:0]   busy, busy_nb;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   regfile_scoreboard #(.WIDTH(16), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .reg_flat(reg_flat),
      .issue_en(issue_en), .issue_reg(issue_reg), .wb_en(wb_en), .wb_reg(wb_reg),
      .wb_data(wb_data), .hz1(hz1), .hz2(hz2), .stall(stall), .busy(busy)
   );

   regfile_scoreboard #(.WIDTH(16), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
      .rd_data1(rd_data1_nb), .rd_data2(rd_data2_nb), .reg_flat(reg_flat_nb),
      .issue_en(issue_en), .issue_reg(issue_reg), .wb_en(wb_en), .wb_reg(wb_reg),
      .wb_data(wb_data), .hz1(hz1_nb), .hz2(hz2_nb), .stall(stall_nb), .busy(busy_nb)
   );

   typedef struct {
      logic        wb_en;
      logic [2:0]  wb_reg;
      logic [15:0] wb_data;
      logic        issue_en;
      logic [2:0]  issue_reg;
      logic [2:0]  sel1;
      logic [2:0]  sel2;
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic        hz1;
      logic        hz2;
      logic [7:0]  busy;
   } vec_t;

   vec_t v[15];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                        input logic ie, input logic [2:0] ir, input logic [2:0] s1, input logic [2:0] s2);
      wb_en = we; wb_reg = wr; wb_data = wd;
      issue_en = ie; issue_reg = ir;
      rd_sel1 = s1; rd_sel2 = s2;
   endtask

   initial begin
      //      wb  reg  data      iss reg  s1  s2   rd1       rd2       h1 h2 busy
      v[0]  = '{1, 3'd3, 16'hBEEF, 0, 3'd0, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 0, 0, 8'h00};
      v[1]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00};
      v[2]  = '{0, 3'd0, 16'h0000, 1, 3'd2, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 0, 8'h00};
      v[3]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 3'd3, 16'h0000, 16'hBEEF, 1, 0, 8'h04};
      v[4]  = '{1, 3'd2, 16'h0042, 0, 3'd0, 3'd2, 3'd2, 16'h0042, 16'h0042, 0, 0, 8'h04};
      v[5]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 3'd0, 16'h0042, 16'h0000, 0, 0, 8'h00};
      v[6]  = '{0, 3'd0, 16'h0000, 1, 3'd4, 3'd0, 3'd0, 16'h0000, 16'h0000, 0, 0, 8'h00};
      v[7]  = '{1, 3'd4, 16'hABCD, 1, 3'd4, 3'd4, 3'd0, 16'hABCD, 16'h0000, 0, 0, 8'h10};
      v[8]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd4, 3'd4, 16'hABCD, 16'hABCD, 1, 1, 8'h10};
      v[9]  = '{1, 3'd4, 16'h5555, 1, 3'd6, 3'd6, 3'd1, 16'h0000, 16'h0000, 0, 0, 8'h10};
      v[10] = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd6, 3'd6, 16'h0000, 16'h0000, 1, 1, 8'h40};
      v[11] = '{1, 3'd6, 16'h6666, 1, 3'd1, 3'd6, 3'd6, 16'h6666, 16'h6666, 0, 0, 8'h40};
      v[12] = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd1, 3'd6, 16'h0000, 16'h6666, 1, 0, 8'h02};
      v[13] = '{0, 3'd0, 16'h0000, 1, 3'd5, 3'd5, 3'd7, 16'h0000, 16'h0000, 0, 0, 8'h02};
      v[14] = '{1, 3'd5, 16'h1234, 0, 3'd0, 3'd0, 3'd5, 16'h0000, 16'h1234, 0, 0, 8'h22};

      rst_n = 1'b0;
      drive(0, 0, 16'h0, 0, 0, 0, 0);
      #2;
      chk("reset_busy", busy, 8'h00);
      chk("reset_flat", reg_flat, 128'h0);
      chk("reset_stall", stall, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1 drive(v[i].wb_en, v[i].wb_reg, v[i].wb_data, v[i].issue_en, v[i].issue_reg, v[i].sel1, v[i].sel2);
         #2;
         chk($sformatf("v%0d_rd1", i), rd_data1, v[i].rd1);
         chk($sformatf("v%0d_rd2", i), rd_data2, v[i].rd2);
         chk($sformatf("v%0d_hz1", i), hz1, v[i].hz1);
         chk($sformatf("v%0d_hz2", i), hz2, v[i].hz2);
         chk($sformatf("v%0d_stall", i), stall, v[i].hz1 | v[i].hz2);
         chk($sformatf("v%0d_busy", i), busy, v[i].busy);
         chk($sformatf("v%0d_busy_nb", i), busy_nb, v[i].busy);
      end

      // Forwarding on vs off with the same write-back into a pending register.
      @(posedge clk);
      #1 drive(0, 0, 16'h0, 1, 3'd5, 3'd0, 3'd5);
      #2 chk("pre_byp_busy", busy, 8'h02);
      @(posedge clk);
      #1 drive(1, 3'd5, 16'h7777, 0, 0, 3'd0, 3'd5);
      #2;
      chk("byp_rd2", rd_data2, 16'h7777);
      chk("byp_hz2", hz2, 1'b0);
      chk("byp_flat_no_fwd", reg_flat[95:80], 16'h1234);
      chk("nobyp_rd2", rd_data2_nb, 16'h1234);
      chk("nobyp_hz2", hz2_nb, 1'b1);
      chk("nobyp_stall", stall_nb, 1'b1);
      @(posedge clk);
      #1 drive(0, 0, 16'h0, 0, 0, 3'd1, 3'd5);
      #2;
      chk("flat_all", reg_flat, 128'h0000_6666_7777_5555_BEEF_0042_0000_0000);
      chk("flat_reg3", reg_flat[63:48], 16'hBEEF);
      chk("pre_rst_stall", stall, 1'b1);
      chk("pre_rst_busy", busy, 8'h02);

      // Asynchronous reset mid-cycle, then a late write-back after release.
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_flat", reg_flat, 128'h0);
      chk("async_rst_busy", busy, 8'h00);
      chk("async_rst_stall", stall, 1'b0);
      chk("async_rst_hz1", hz1, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, 3'd1, 16'h00AA, 0, 0, 3'd1, 3'd0);
      #2;
      chk("late_wb_rd1", rd_data1, 16'h00AA);
      chk("late_wb_hz1", hz1, 1'b0);
      @(posedge clk);
      #1 drive(0, 0, 16'h0, 0, 0, 3'd1, 3'd0);
      #2;
      chk("late_wb_busy", busy, 8'h00);
      chk("late_wb_flat", reg_flat, 128'h0000_0000_0000_0000_0000_0000_00AA_0000);
      chk("late_wb_rd1_stored", rd_data1, 16'h00AA);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
